// File: rtl/lc3_pipeline_controller.sv
// Sequencing controller for the LC3 five-stage pipeline: fill, steady run,
// multi-phase memory stalls, branch flush/refill and operand bypass selects.
module lc3_pipeline_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_MEM  = 2'd2
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] MS_READ     = 2'd0;
  localparam logic [1:0] MS_IND_READ = 2'd1;
  localparam logic [1:0] MS_WRITE    = 2'd2;
  localparam logic [1:0] MS_IDLE     = 2'd3;

  function automatic logic op_is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       mem_done_q, mem_done_d;
  logic [2:0] load_dst_q, load_dst_d;
  logic       is_load_q, is_load_d;
  logic       ind_pending_q, ind_pending_d;

  logic [3:0] exec_op;
  logic [3:0] dec_op;
  logic       exec_mem;
  logic       exec_ctrl;
  logic       mem_enter;
  logic       run_go;
  logic       src1_used;
  logic       src2_used;
  logic       alu_hit_1, alu_hit_2;
  logic       mem_hit_1, mem_hit_2;
  logic       unused_ir_bits;

  assign exec_op   = IR_Exec[15:12];
  assign dec_op    = IR[15:12];
  assign exec_mem  = op_is_load(exec_op) || op_is_store(exec_op);
  assign exec_ctrl = (exec_op == OP_BR) || (exec_op == OP_JMP);
  assign mem_enter = (state_q == S_RUN) && exec_mem && !mem_done_q;
  assign run_go    = (state_q == S_RUN) && !mem_enter && !exec_ctrl && complete_instr;

  assign unused_ir_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

  // Which decode-stage source fields actually carry a register operand.
  assign src1_used = op_is_alu(dec_op) || op_is_load(dec_op) || op_is_store(dec_op);
  assign src2_used = ((dec_op == OP_ADD) || (dec_op == OP_AND)) && !IR[5];

  assign alu_hit_1 = op_is_alu(exec_op) && (IR_Exec[11:9] == IR[8:6]) && src1_used;
  assign alu_hit_2 = op_is_alu(exec_op) && (IR_Exec[11:9] == IR[2:0]) && src2_used;
  assign mem_hit_1 = mem_done_q && is_load_q && (load_dst_q == IR[8:6]) && src1_used;
  assign mem_hit_2 = mem_done_q && is_load_q && (load_dst_q == IR[2:0]) && src2_used;

  always_comb begin
    enable_updatePC  = 1'b0;
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    br_taken         = 1'b0;
    bypass_alu_1     = 1'b0;
    bypass_alu_2     = 1'b0;
    bypass_mem_1     = 1'b0;
    bypass_mem_2     = 1'b0;
    mem_state        = MS_IDLE;
    if (!reset) begin
      case (state_q)
        S_FILL: begin
          enable_updatePC  = 1'b1;
          enable_fetch     = 1'b1;
          enable_decode    = (cnt_q >= 2'd1);
          enable_execute   = (cnt_q >= 2'd2);
          enable_writeback = (cnt_q == 2'd3);
        end
        S_RUN: begin
          if (mem_enter) begin
            enable_updatePC = 1'b0;
          end else if (exec_ctrl) begin
            enable_updatePC = 1'b1;
            br_taken = (exec_op == OP_JMP) || ((IR_Exec[11:9] & NZP) != 3'b000);
          end else if (run_go) begin
            enable_updatePC  = 1'b1;
            enable_fetch     = 1'b1;
            enable_decode    = 1'b1;
            enable_execute   = 1'b1;
            enable_writeback = 1'b1;
            bypass_alu_1     = alu_hit_1;
            bypass_alu_2     = alu_hit_2;
            bypass_mem_1     = mem_hit_1 && !alu_hit_1;
            bypass_mem_2     = mem_hit_2 && !alu_hit_2;
          end
        end
        S_MEM: begin
          if (ind_pending_q) begin
            mem_state = MS_IND_READ;
          end else if (is_load_q) begin
            mem_state = MS_READ;
          end else begin
            mem_state = MS_WRITE;
          end
        end
        default: mem_state = MS_IDLE;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_done_d    = mem_done_q;
    load_dst_d    = load_dst_q;
    is_load_d     = is_load_q;
    ind_pending_d = ind_pending_q;
    case (state_q)
      S_FILL: begin
        if (complete_instr) begin
          if (cnt_q == 2'd3) begin
            state_d = S_RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_RUN: begin
        if (mem_enter) begin
          state_d       = S_MEM;
          is_load_d     = op_is_load(exec_op);
          ind_pending_d = (exec_op == OP_LDI) || (exec_op == OP_STI);
          if (op_is_load(exec_op)) begin
            load_dst_d = IR_Exec[11:9];
          end
        end else if (exec_ctrl) begin
          state_d    = S_FILL;
          cnt_d      = 2'd0;
          mem_done_d = 1'b0;
        end else if (complete_instr) begin
          // A frozen cycle keeps mem_done so the same IR_Exec is not re-issued.
          mem_done_d = 1'b0;
        end
      end
      S_MEM: begin
        if (complete_data) begin
          if (ind_pending_q) begin
            ind_pending_d = 1'b0;
          end else begin
            state_d    = S_RUN;
            mem_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_FILL;
      cnt_q         <= 2'd0;
      mem_done_q    <= 1'b0;
      load_dst_q    <= 3'd0;
      is_load_q     <= 1'b0;
      ind_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_done_q    <= mem_done_d;
      load_dst_q    <= load_dst_d;
      is_load_q     <= is_load_d;
      ind_pending_q <= ind_pending_d;
    end
  end

endmodule

// File: tb/tb_lc3_pipeline_controller.sv
// Bench for lc3_pipeline_controller: directed scenarios plus random traffic,
// all compared cycle by cycle against a phase-queue reference model.
module tb_lc3_pipeline_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0]  mem_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pipeline mode (0 filling, 1 running, 2 memory access).
  int         m_mode;
  int         m_filled;
  bit         m_done;
  bit         m_last_load;
  logic [2:0] m_ldst;
  int         m_phases[$];

  lc3_pipeline_controller dut (
    .clock(clock), .reset(reset),
    .complete_instr(complete_instr), .complete_data(complete_data),
    .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP),
    .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch),
    .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .br_taken(br_taken),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .mem_state(mem_state)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit op_alu(input logic [3:0] op);
    return op inside {4'd1, 4'd5, 4'd9, 4'd14};
  endfunction
  function automatic bit op_load(input logic [3:0] op);
    return op inside {4'd2, 4'd6, 4'd10};
  endfunction
  function automatic bit op_store(input logic [3:0] op);
    return op inside {4'd3, 4'd7, 4'd11};
  endfunction

  // {updatePC, fetch, decode, execute, writeback, br, ba1, ba2, bm1, bm2, mem_state}
  function automatic logic [11:0] model_outputs();
    logic [3:0] xop;
    logic [3:0] dop;
    bit s1, s2, ba1, ba2, bm1, bm2, br;
    xop = IR_Exec[15:12];
    dop = IR[15:12];
    if (reset) return 12'h003;
    if (m_mode == 0)
      return {2'b11, m_filled >= 1, m_filled >= 2, m_filled >= 3, 5'b0, 2'd3};
    if (m_mode == 2)
      return {10'b0, 2'(m_phases[0])};
    if ((op_load(xop) || op_store(xop)) && !m_done) return 12'h003;
    if (xop == 4'd0 || xop == 4'd12) begin
      br = (xop == 4'd12) || ((IR_Exec[11:9] & NZP) != 3'b0);
      return {1'b1, 4'b0, br, 4'b0, 2'd3};
    end
    if (!complete_instr) return 12'h003;
    s1  = op_alu(dop) || op_load(dop) || op_store(dop);
    s2  = (dop == 4'd1 || dop == 4'd5) && (IR[5] == 1'b0);
    ba1 = op_alu(xop) && IR_Exec[11:9] == IR[8:6] && s1;
    ba2 = op_alu(xop) && IR_Exec[11:9] == IR[2:0] && s2;
    bm1 = !ba1 && m_done && m_last_load && m_ldst == IR[8:6] && s1;
    bm2 = !ba2 && m_done && m_last_load && m_ldst == IR[2:0] && s2;
    return {5'b11111, 1'b0, ba1, ba2, bm1, bm2, 2'd3};
  endfunction

  task automatic model_clock();
    logic [3:0] xop;
    xop = IR_Exec[15:12];
    if (reset) begin
      m_mode = 0; m_filled = 0; m_done = 0; m_last_load = 0; m_ldst = 3'd0;
      m_phases.delete();
    end else if (m_mode == 0) begin
      if (complete_instr) begin
        if (m_filled == 3) begin
          m_mode = 1; m_filled = 0;
        end else begin
          m_filled++;
        end
      end
    end else if (m_mode == 1) begin
      if ((op_load(xop) || op_store(xop)) && !m_done) begin
        m_mode = 2;
        case (xop)
          4'd2, 4'd6: m_phases.push_back(0);
          4'd3, 4'd7: m_phases.push_back(2);
          4'd10: begin m_phases.push_back(1); m_phases.push_back(0); end
          default: begin m_phases.push_back(1); m_phases.push_back(2); end
        endcase
        m_last_load = op_load(xop);
        if (op_load(xop)) m_ldst = IR_Exec[11:9];
      end else if (xop == 4'd0 || xop == 4'd12) begin
        m_mode = 0; m_filled = 0; m_done = 0;
      end else if (complete_instr) begin
        m_done = 0;
      end
    end else begin
      if (complete_data) begin
        void'(m_phases.pop_front());
        if (m_phases.size() == 0) begin
          m_mode = 1; m_done = 1;
        end
      end
    end
  endtask

  // Apply inputs, let them settle, compare the full output set against the model.
  task automatic drive(input string tag, input logic rst, input logic ci, input logic cd,
                       input logic [15:0] ir, input logic [15:0] irx, input logic [2:0] nzp);
    logic [11:0] obs;
    reset = rst; complete_instr = ci; complete_data = cd;
    IR = ir; IR_Exec = irx; NZP = nzp;
    #2;
    obs = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
           br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state};
    check_val(tag, {4'b0, obs}, {4'b0, model_outputs()});
  endtask

  task automatic tick();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic run_fill(input int n);
    for (int i = 0; i < n; i++) begin
      drive("refill", 1'b0, 1'b1, 1'b0, 16'h1000, 16'h1000, 3'b001);
      tick();
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0]  ops [16] = '{4'd1, 4'd5, 4'd9, 4'd14, 4'd1, 4'd5, 4'd2, 4'd6,
                              4'd10, 4'd3, 4'd7, 4'd11, 4'd0, 4'd12, 4'd1, 4'd4};
    logic [15:0] w;
    w        = 16'($urandom);
    w[15:12] = ops[$urandom_range(0, 15)];
    w[11:9]  = 3'($urandom_range(0, 3));
    w[8:6]   = 3'($urandom_range(0, 3));
    w[2:0]   = 3'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    logic [1:0] ldi_ms [5] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    logic       ldi_cd [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    m_mode = 0; m_filled = 0; m_done = 0; m_last_load = 0; m_ldst = 3'd0;

    for (int i = 0; i < 2; i++) begin
      drive("reset", 1'b1, 1'b1, 1'b0, 16'h1000, 16'h1000, 3'b001);
      check_val("reset_ms", 16'(mem_state), 16'd3);
      check_val("reset_upc", 16'(enable_updatePC), 16'd0);
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      drive("fill", 1'b0, 1'b1, 1'b0, 16'h1000, 16'h1000, 3'b001);
      check_val("fill_fetch", 16'(enable_fetch), 16'd1);
      check_val("fill_dec", 16'(enable_decode), 16'(i >= 1));
      check_val("fill_exe", 16'(enable_execute), 16'(i >= 2));
      check_val("fill_wb", 16'(enable_writeback), 16'(i >= 3));
      tick();
    end

    // LDI with two data phases
    drive("ldi_detect", 1'b0, 1'b1, 1'b0, 16'h1000, 16'hA200, 3'b001);
    check_val("ldi_detect_upc", 16'(enable_updatePC), 16'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive("ldi_mem", 1'b0, 1'b1, ldi_cd[i], 16'h1000, 16'hA200, 3'b001);
      check_val("ldi_ms", 16'(mem_state), 16'(ldi_ms[i]));
      check_val("ldi_exe", 16'(enable_execute), 16'd0);
      tick();
    end
    drive("ldi_exit", 1'b0, 1'b1, 1'b0, 16'h1000, 16'hA200, 3'b001);
    check_val("ldi_exit_ms", 16'(mem_state), 16'd3);
    check_val("ldi_exit_exe", 16'(enable_execute), 16'd1);
    tick();

    // LD R3 followed by a dependent ADD: load-data bypass on the exit cycle only
    drive("ld_detect", 1'b0, 1'b1, 1'b0, 16'h1000, 16'h2600, 3'b001);
    tick();
    drive("ld_mem", 1'b0, 1'b1, 1'b1, 16'h18C3, 16'h2600, 3'b001);
    check_val("ld_ms", 16'(mem_state), 16'd0);
    tick();
    drive("ld_exit", 1'b0, 1'b1, 1'b0, 16'h18C3, 16'h2600, 3'b001);
    check_val("bm1_on", 16'(bypass_mem_1), 16'd1);
    check_val("bm2_on", 16'(bypass_mem_2), 16'd1);
    tick();
    drive("ld_after", 1'b0, 1'b1, 1'b0, 16'h18C3, 16'h1000, 3'b001);
    check_val("bm1_off", 16'(bypass_mem_1), 16'd0);
    tick();

    // BRz taken, then refill
    drive("brz_taken", 1'b0, 1'b1, 1'b0, 16'h1000, 16'h0403, 3'b010);
    check_val("brz_taken", 16'(br_taken), 16'd1);
    check_val("brz_fetch", 16'(enable_fetch), 16'd0);
    tick();
    drive("brz_after", 1'b0, 1'b1, 1'b0, 16'h1000, 16'h1000, 3'b010);
    check_val("br_pulse", 16'(br_taken), 16'd0);
    check_val("br_refill_dec", 16'(enable_decode), 16'd0);
    tick();
    run_fill(3);

    // BRz not taken still flushes
    drive("brz_not", 1'b0, 1'b1, 1'b0, 16'h1000, 16'h0403, 3'b100);
    check_val("brz_not_taken", 16'(br_taken), 16'd0);
    check_val("brz_not_upc", 16'(enable_updatePC), 16'd1);
    tick();
    run_fill(4);

    // ALU bypass
    drive("byp_reg", 1'b0, 1'b1, 1'b0, 16'h18C3, 16'h1642, 3'b001);
    check_val("ba1_reg", 16'(bypass_alu_1), 16'd1);
    check_val("ba2_reg", 16'(bypass_alu_2), 16'd1);
    tick();
    drive("byp_imm", 1'b0, 1'b1, 1'b0, 16'h18E3, 16'h1642, 3'b001);
    check_val("ba1_imm", 16'(bypass_alu_1), 16'd1);
    check_val("ba2_imm", 16'(bypass_alu_2), 16'd0);
    tick();

    // Instruction memory stall
    for (int i = 0; i < 3; i++) begin
      drive("istall", 1'b0, 1'b0, 1'b0, 16'h18E3, 16'h1642, 3'b001);
      check_val("istall_fetch", 16'(enable_fetch), 16'd0);
      tick();
    end
    drive("istall_end", 1'b0, 1'b1, 1'b0, 16'h18E3, 16'h1642, 3'b001);
    check_val("istall_resume", 16'(enable_fetch), 16'd1);
    tick();

    // Reset in the middle of a memory access
    drive("rmem_detect", 1'b0, 1'b1, 1'b0, 16'h1000, 16'h2200, 3'b001);
    tick();
    drive("rmem_mem", 1'b0, 1'b1, 1'b0, 16'h1000, 16'h2200, 3'b001);
    check_val("rmem_ms", 16'(mem_state), 16'd0);
    tick();
    drive("rmem_reset", 1'b1, 1'b1, 1'b0, 16'h1000, 16'h2200, 3'b001);
    check_val("rmem_reset_ms", 16'(mem_state), 16'd3);
    check_val("rmem_reset_wb", 16'(enable_writeback), 16'd0);
    tick();
    drive("rmem_after", 1'b0, 1'b1, 1'b0, 16'h1000, 16'h1000, 3'b001);
    check_val("rmem_after_ms", 16'(mem_state), 16'd3);
    check_val("rmem_after_wb", 16'(enable_writeback), 16'd0);
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic rst, ci, cd;
      rst = ($urandom_range(0, 249) == 0);
      ci  = (m_mode == 1 && m_done) ? 1'b1 : ($urandom_range(0, 7) != 0);
      cd  = ($urandom_range(0, 2) == 0);
      drive("rand", rst, ci, cd, rand_instr(), rand_instr(), 3'($urandom_range(0, 7)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
